// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one instruction-memory request at a time and
// loads the IF/ID register; branches redirect immediately or after an outstanding fetch retires.
module pc_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_INC   = 16'h0001
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] pc_add_a,
    output logic [15:0] pc_add_b,
    input  logic [15:0] pc_add_sum,
    input  logic        branch_valid,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_next
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StHold = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        redir_pend_q, redir_pend_d;
    logic [15:0] redir_pc_q, redir_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [15:0] if_instr_q, if_instr_d;
    logic [15:0] if_pc_q, if_pc_d;
    logic [15:0] if_pc_next_q, if_pc_next_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= 16'h0000;
            if_valid_q   <= 1'b0;
            if_instr_q   <= 16'h0000;
            if_pc_q      <= 16'h0000;
            if_pc_next_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            if_pc_next_q <= if_pc_next_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        if_pc_next_d = if_pc_next_q;

        case (state_q)
            StIdle: begin
                state_d    = StReq;
                if_valid_d = 1'b0;
                if (branch_valid) begin
                    pc_d = branch_target;
                end
            end
            StReq: begin
                if (imem_ack) begin
                    // Returning data belongs to a path that has since been redirected: drop it.
                    if (redir_pend_q || branch_valid) begin
                        pc_d         = branch_valid ? branch_target : redir_pc_q;
                        redir_pend_d = 1'b0;
                    end else begin
                        if_instr_d   = imem_rdata;
                        if_pc_d      = pc_q;
                        if_pc_next_d = pc_add_sum;
                        pc_d         = pc_add_sum;
                        if_valid_d   = 1'b1;
                        state_d      = StHold;
                    end
                end else if (branch_valid) begin
                    // The address on the bus must stay put until ack, so park the target.
                    redir_pend_d = 1'b1;
                    redir_pc_d   = branch_target;
                end
            end
            StHold: begin
                if (branch_valid) begin
                    pc_d       = branch_target;
                    if_valid_d = 1'b0;
                    state_d    = StReq;
                end else if (if_ready) begin
                    if_valid_d = 1'b0;
                    state_d    = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign pc_add_a   = pc_q;
    assign pc_add_b   = PC_INC;
    assign imem_req   = (state_q == StReq);
    assign imem_addr  = pc_q;
    assign if_valid   = if_valid_q;
    assign if_instr   = if_instr_q;
    assign if_pc      = if_pc_q;
    assign if_pc_next = if_pc_next_q;

endmodule
